// File: rtl/d_reg_pkg.sv
// d_reg_pkg: shared definitions for the d_reg_pipe family.
//   clog2_min1()    - ceil(log2(n)) but never below 1, so a counter or select
//                     port derived from a small depth still has a legal width.
//   DEFAULT_RST_VAL - data value loaded into every stage on reset unless a
//                     different RST_VAL is supplied.
package d_reg_pkg;

  localparam int unsigned DEFAULT_RST_VAL = 0;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : d_reg_pkg

// File: rtl/d_reg_stage.sv
// d_reg_stage: one enabled data/valid stage of the d_reg_pipe delay chain.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset; loads rst_val and clears valid
//   en      - advance enable; din/vin captured only when 1
//   clr     - synchronous flush of the valid bit; data is left untouched
//   din/vin - data and valid from the previous stage (or the pipe input)
//   rst_val - data value loaded on reset
//   dout    - registered data
//   vout    - registered valid
module d_reg_stage
  import d_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  input  logic [WIDTH-1:0] rst_val,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  // NOTE: registers use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  // NOTE: data is reset as well as valid, so q never shows X after reset even
  // though invalid data is architecturally don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= rst_val;
      vout <= 1'b0;
    end else if (clr) begin
      // Flush wins over enable and leaves the data word where it is.
      vout <= 1'b0;
    end else if (en) begin
      dout <= din;
      vout <= vin;
    end
  end

endmodule : d_reg_stage

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: stallable, programmable-latency data/valid delay line.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (priority over clr and en)
//   en         - advance enable; the whole chain shifts only when 1
//   clr        - synchronous flush of all valid bits (incoming d_valid too)
//   d/d_valid  - input data and qualifier
//   tap_sel    - output tap; delay is tap_sel+1 enabled edges, clamped to
//                the last stage when tap_sel >= DEPTH
//   q/q_valid  - data and valid of the selected stage (combinational mux)
//   fill_count - number of stages holding valid data
//   full/empty - fill_count == DEPTH / fill_count == 0
module d_reg_pipe
  import d_reg_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL),
  parameter int              CW      = clog2_min1(DEPTH + 1),
  parameter int              TW      = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CW-1:0]    fill_count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] data_chain [DEPTH];
  logic [DEPTH-1:0] valid_chain;
  logic [WIDTH-1:0] stage_din  [DEPTH];
  logic [DEPTH-1:0] stage_vin;
  int               tap_idx;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_din[i] = d;
      assign stage_vin[i] = d_valid;
    end else begin : g_link
      assign stage_din[i] = data_chain[i-1];
      assign stage_vin[i] = valid_chain[i-1];
    end

    d_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .din     (stage_din[i]),
      .vin     (stage_vin[i]),
      .rst_val (RST_VAL),
      .dout    (data_chain[i]),
      .vout    (valid_chain[i])
    );
  end

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves q/q_valid unassigned and no latch is inferred.
  always_comb begin
    tap_idx = DEPTH - 1;
    if (int'(tap_sel) < DEPTH) tap_idx = int'(tap_sel);
    q       = data_chain[0];
    q_valid = valid_chain[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (i == tap_idx) begin
        q       = data_chain[i];
        q_valid = valid_chain[i];
      end
    end
  end

  // Tracks popcount(valid_chain) incrementally: a shift brings d_valid in and
  // pushes the last stage's valid out. The result always lies in 0..DEPTH, so
  // the CW-bit modular add/subtract never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fill_count <= '0;
    end else if (en) begin
      fill_count <= fill_count + CW'(d_valid) - CW'(valid_chain[DEPTH-1]);
    end
  end

  assign full  = (fill_count == CW'(DEPTH));
  assign empty = (fill_count == '0);

endmodule : d_reg_pipe

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe: directed self-checking bench for d_reg_pipe.
// Four builds share one stimulus bus: DEPTH=4/RST_VAL=00 (main), DEPTH=4/
// RST_VAL=FF, DEPTH=3 (tap clamping) and DEPTH=1 (plain enabled flop).
module tb_d_reg_pipe;

  logic       clk = 1'b0;
  logic       rst, en, clr, d_valid;
  logic [7:0] d;
  logic [1:0] tap_sel;
  logic       tap1;

  logic [7:0] q,   q_ff,   q3,   q1;
  logic       qv,  qv_ff,  qv3,  qv1;
  logic [2:0] fc,  fc_ff;
  logic [1:0] fc3;
  logic       fc1;
  logic       full, empty, full_ff, empty_ff, full3, empty3, full1, empty1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_reg_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .tap_sel(tap_sel), .q(q), .q_valid(qv), .fill_count(fc),
    .full(full), .empty(empty));

  d_reg_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hFF)) dut_ff (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .tap_sel(tap_sel), .q(q_ff), .q_valid(qv_ff), .fill_count(fc_ff),
    .full(full_ff), .empty(empty_ff));

  d_reg_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .tap_sel(tap_sel), .q(q3), .q_valid(qv3), .fill_count(fc3),
    .full(full3), .empty(empty3));

  d_reg_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .tap_sel(tap1), .q(q1), .q_valid(qv1), .fill_count(fc1),
    .full(full1), .empty(empty1));

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; d = 8'h00; d_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] val, input logic vld);
    d = val; d_valid = vld; en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    tap_sel = 2'd0; tap1 = 1'b0;
    do_reset();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (qv !== 1'b0) begin errors++; $display("FAIL reset_qv got %b exp 0", qv); end
    checks++; if (fc !== 3'd0) begin errors++; $display("FAIL reset_fc got %0d exp 0", fc); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (q_ff !== 8'hFF) begin errors++; $display("FAIL reset_q_ff got %h exp ff", q_ff); end
  endtask

  // A single valid A5 must appear at the tap exactly on edge tap+1, once.
  task automatic test_latency(input logic [1:0] tap);
    int lat;
    lat = int'(tap) + 1;
    do_reset();
    tap_sel = tap;
    push(8'hA5, 1'b1);
    d = 8'h00; d_valid = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) step();
      checks++;
      if (qv !== (k == lat)) begin
        errors++; $display("FAIL lat%0d_qv edge %0d got %b exp %b", tap, k, qv, (k == lat));
      end
      if (k == lat) begin
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL lat%0d_q got %h exp a5", tap, q); end
      end
      checks++;
      if (fc !== ((k <= 4) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL lat%0d_fc edge %0d got %0d exp %0d", tap, k, fc, (k <= 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q [3];
    exp_q = '{8'h11, 8'h22, 8'h33};
    do_reset();
    tap_sel = 2'd3;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    en = 1'b0; d = 8'h99; d_valid = 1'b1;
    tap_sel = 2'd2;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (fc !== 3'd3) begin errors++; $display("FAIL stall_fc got %0d exp 3", fc); end
      checks++; if (q !== 8'h11 || qv !== 1'b1) begin
        errors++; $display("FAIL stall_q got %h/%b exp 11/1", q, qv);
      end
    end
    tap_sel = 2'd3;
    for (int k = 0; k < 4; k++) begin
      push(8'h00, 1'b0);
      if (k < 3) begin
        checks++; if (q !== exp_q[k] || qv !== 1'b1) begin
          errors++; $display("FAIL resume_q%0d got %h/%b exp %h/1", k, q, qv, exp_q[k]);
        end
      end else begin
        checks++; if (qv !== 1'b0) begin errors++; $display("FAIL resume_tail_qv got %b exp 0", qv); end
      end
      checks++;
      if (fc !== ((k == 0) ? 3'd3 : 3'(3 - k))) begin
        errors++; $display("FAIL resume_fc%0d got %0d exp %0d", k, fc, (k == 0) ? 3 : 3 - k);
      end
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    tap_sel = 2'd3;
    for (int k = 1; k <= 4; k++) begin
      push(8'(k), 1'b1);
      checks++; if (fc !== 3'(k)) begin errors++; $display("FAIL fill_fc%0d got %0d exp %0d", k, fc, k); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    for (int k = 5; k <= 6; k++) begin
      push(8'(k), 1'b1);
      checks++; if (fc !== 3'd4) begin errors++; $display("FAIL stream_fc got %0d exp 4", fc); end
      checks++; if (q !== 8'(k - 3)) begin errors++; $display("FAIL stream_q got %h exp %h", q, 8'(k - 3)); end
    end
    for (int k = 1; k <= 4; k++) begin
      push(8'h00, 1'b0);
      checks++; if (fc !== 3'(4 - k)) begin errors++; $display("FAIL drain_fc got %0d exp %0d", fc, 4 - k); end
      if (k < 4) begin
        checks++; if (q !== 8'(k + 3) || qv !== 1'b1) begin
          errors++; $display("FAIL drain_q got %h/%b exp %h/1", q, qv, 8'(k + 3));
        end
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full got %b exp 0", full); end
  endtask

  task automatic test_clear();
    do_reset();
    push(8'hA1, 1'b1);
    push(8'hB2, 1'b1);
    push(8'hC3, 1'b1);
    checks++; if (fc !== 3'd3) begin errors++; $display("FAIL pre_clr_fc got %0d exp 3", fc); end
    clr = 1'b1; en = 1'b1; d = 8'hEE; d_valid = 1'b1;
    step();
    clr = 1'b0; en = 1'b0; d_valid = 1'b0;
    checks++; if (fc !== 3'd0) begin errors++; $display("FAIL clr_fc got %0d exp 0", fc); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty got %b exp 1", empty); end
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t);
      #1;
      checks++; if (qv !== 1'b0) begin errors++; $display("FAIL clr_qv tap%0d got %b exp 0", t, qv); end
    end
    // Data words stay put under clr, so tap 0 still holds the last push.
    tap_sel = 2'd0;
    #1;
    checks++; if (q !== 8'hC3) begin errors++; $display("FAIL clr_data got %h exp c3", q); end
    // rst together with clr and en: reset value must win on both builds.
    push(8'h5A, 1'b1);
    rst = 1'b1; clr = 1'b1; en = 1'b1; d = 8'h77; d_valid = 1'b1;
    step();
    rst = 1'b0; clr = 1'b0; en = 1'b0; d_valid = 1'b0;
    checks++; if (q_ff !== 8'hFF) begin errors++; $display("FAIL rstclr_q_ff got %h exp ff", q_ff); end
    checks++; if (fc_ff !== 3'd0) begin errors++; $display("FAIL rstclr_fc_ff got %0d exp 0", fc_ff); end
    checks++; if (q !== 8'h00 || qv !== 1'b0) begin
      errors++; $display("FAIL rstclr_q got %h/%b exp 00/0", q, qv);
    end
  endtask

  task automatic test_tap_bounds();
    do_reset();
    push(8'h10, 1'b1);
    push(8'h20, 1'b1);
    push(8'h30, 1'b1);
    en = 1'b0; d_valid = 1'b0;
    checks++; if (fc3 !== 2'd3 || full3 !== 1'b1) begin
      errors++; $display("FAIL d3_full got %0d/%b exp 3/1", fc3, full3);
    end
    tap_sel = 2'd2; #1;
    checks++; if (q3 !== 8'h10 || qv3 !== 1'b1) begin errors++; $display("FAIL d3_tap2 got %h/%b exp 10/1", q3, qv3); end
    tap_sel = 2'd3; #1;
    checks++; if (q3 !== 8'h10 || qv3 !== 1'b1) begin errors++; $display("FAIL d3_tap3 got %h/%b exp 10/1", q3, qv3); end
    tap_sel = 2'd0; #1;
    checks++; if (q3 !== 8'h30) begin errors++; $display("FAIL d3_tap0 got %h exp 30", q3); end
  endtask

  task automatic test_depth1();
    do_reset();
    push(8'h7E, 1'b1);
    checks++; if (q1 !== 8'h7E || qv1 !== 1'b1) begin errors++; $display("FAIL d1_q got %h/%b exp 7e/1", q1, qv1); end
    checks++; if (fc1 !== 1'b1 || full1 !== 1'b1) begin errors++; $display("FAIL d1_full got %b/%b exp 1/1", fc1, full1); end
    en = 1'b0; d = 8'h00; d_valid = 1'b0;
    step();
    step();
    tap1 = 1'b1; #1;
    checks++; if (q1 !== 8'h7E || qv1 !== 1'b1) begin errors++; $display("FAIL d1_hold got %h/%b exp 7e/1", q1, qv1); end
    tap1 = 1'b0;
    push(8'h00, 1'b0);
    checks++; if (qv1 !== 1'b0 || empty1 !== 1'b1) begin
      errors++; $display("FAIL d1_drain got %b/%b exp 0/1", qv1, empty1);
    end
  endtask

  initial begin
    test_reset();
    test_latency(2'd2);
    test_latency(2'd0);
    test_latency(2'd3);
    test_stall();
    test_fill_drain();
    test_clear();
    test_tap_bounds();
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_d_reg_pipe
